io_port_bank: RTL

Memory-mapped I/O responder on the CPU's port bus (dirport/outport/we/inport). Decodes the 5-bit port address and provides:
- eight read/write output registers, with register 0 driving board LEDs;
- a synchronised switch input;
- a 4-deep receive FIFO fed by an external valid/ready producer;
- a programmable down-counting timer with a sticky flag.

It sits beside the CPU at top level and is the target of every port read and write the CPU issues.

---
 rtl/io_port_bank.sv | 117 +++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// Port-bus responder: eight R/W registers (R0 drives the LEDs), synchronised switches,
// a 4-entry receive FIFO and a reloading down-counter timer with a sticky flag.
module io_port_bank (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  dirport,
  input  logic [15:0] outport,
  input  logic        we,
  output logic [15:0] inport,
  output logic [15:0] leds,
  input  logic [15:0] sw,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [4:0] ADDR_SW     = 5'h10;
  localparam logic [4:0] ADDR_RXDATA = 5'h11;
  localparam logic [4:0] ADDR_STATUS = 5'h12;
  localparam logic [4:0] ADDR_TIMER  = 5'h13;
  localparam logic [4:0] ADDR_TFCLR  = 5'h14;

  logic [15:0] regs [8];
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;

  logic [15:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  logic [15:0] period;
  logic [15:0] counter;
  logic        flag;
  logic        timer_wr;
  logic        flag_clr;
  logic        reload;

  assign fifo_empty = (count == 3'd0);
  assign fifo_full  = (count == 3'd4);
  assign rx_ready   = !fifo_full;
  assign push       = rx_valid && rx_ready;
  assign pop        = we && (dirport == ADDR_RXDATA) && !fifo_empty;

  assign timer_wr = we && (dirport == ADDR_TIMER);
  assign flag_clr = we && (dirport == ADDR_TFCLR);
  assign reload   = (period != 16'd0) && (counter == 16'd0);

  assign leds = regs[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (we && (dirport[4:3] == 2'b00)) regs[dirport[2:0]] <= outport;
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // A CPU write to TIMER overrides a reload, but the reload still raises the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      period  <= '0;
      counter <= '0;
      flag    <= 1'b0;
    end else begin
      if (timer_wr) begin
        period  <= outport;
        counter <= outport;
      end else if (period != 16'd0) begin
        counter <= reload ? period : counter - 16'd1;
      end
      if (reload)        flag <= 1'b1;
      else if (flag_clr) flag <= 1'b0;
    end
  end

  always_comb begin
    inport = '0;
    if (dirport[4:3] == 2'b00) begin
      inport = regs[dirport[2:0]];
    end else begin
      case (dirport)
        ADDR_SW:     inport = sw_sync;
        ADDR_RXDATA: inport = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];
        ADDR_STATUS: inport = {10'b0, flag, count, fifo_full, fifo_empty};
        ADDR_TIMER:  inport = counter;
        default:     inport = '0;
      endcase
    end
  end

endmodule
